// File: rtl/rf_dump_tx.sv
// rf_dump_tx: streams the register file of the single-cycle computer out as 8N1 UART bytes.
// It drives reg_sel, captures reg_data, and sends each register big-endian. After the last
// register it pulses done.
// Optional feature: define RF_DUMP_IDX_EN to put an index byte {3'b000, reg_sel} in front of
// the data bytes of each register.
module rf_dump_tx #(
  parameter int unsigned CLK_DIV  = 434,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TimerW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef RF_DUMP_IDX_EN
  localparam int unsigned NumBytes = 5;
`else
  localparam int unsigned NumBytes = 4;
`endif
  localparam int unsigned WordW = NumBytes * 8;

  localparam logic [TimerW-1:0] BitLast  = TimerW'(CLK_DIV - 1);
  localparam logic [2:0]        ByteLast = 3'(NumBytes - 1);
  localparam logic [4:0]        SelLast  = 5'(NUM_REGS - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSel   = 3'd1;
  localparam logic [2:0] StCap   = 3'd2;
  localparam logic [2:0] StStart = 3'd3;
  localparam logic [2:0] StData  = 3'd4;
  localparam logic [2:0] StStop  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [7:0]        byte_q, byte_d;
  logic [4:0]        reg_sel_q, reg_sel_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic [WordW-1:0]  capture;

`ifdef RF_DUMP_IDX_EN
  assign capture = {3'b000, reg_sel_q, reg_data};
`else
  assign capture = reg_data;
`endif

  assign bit_end = (timer_q == BitLast);

  // Next-state logic: the FSM, bit timer and shifters. tx is computed one edge ahead so that
  // the registered line changes exactly at each bit boundary.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    byte_d     = byte_q;
    reg_sel_d  = reg_sel_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q == StStart || state_q == StData || state_q == StStop) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d    = 1'b1;
          reg_sel_d = 5'd0;
          state_d   = StSel;
        end
      end
      // reg_sel was updated on entry; give reg_data one full cycle to settle.
      StSel: state_d = StCap;
      StCap: begin
        word_d     = capture;
        byte_cnt_d = 3'd0;
        tx_d       = 1'b0;
        state_d    = StStart;
      end
      StStart: begin
        if (bit_end) begin
          byte_d    = word_q[WordW-1 -: 8];
          tx_d      = word_q[WordW-8];
          word_d    = word_q << 8;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d      = byte_q[1];
            byte_d    = {1'b0, byte_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (byte_cnt_q != ByteLast) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            tx_d       = 1'b0;
            state_d    = StStart;
          end else if (reg_sel_q < SelLast) begin
            reg_sel_d = reg_sel_q + 5'd1;
            state_d   = StSel;
          end else begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            reg_sel_d = 5'd0;
            state_d   = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any frame in flight and parks the line high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_cnt_q <= 3'd0;
      word_q     <= '0;
      byte_q     <= 8'd0;
      reg_sel_q  <= 5'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      reg_sel_q  <= reg_sel_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign reg_sel = reg_sel_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rf_dump_tx.sv
// Directed bench for rf_dump_tx: instance a has 32 registers and instance b has 2 registers,
// both with CLK_DIV=4. A UART monitor decodes the bytes from each tx line.
module tb_rf_dump_tx;

`ifdef RF_DUMP_IDX_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int PER_REG = 2 + NB * 40;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic [4:0]  sel_a, sel_b;
  logic [31:0] data_a, data_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign data_a = rf_a[sel_a];
  assign data_b = rf_b[sel_b];

  rf_dump_tx #(.CLK_DIV(4), .NUM_REGS(32)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .reg_sel(sel_a), .reg_data(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  rf_dump_tx #(.CLK_DIV(4), .NUM_REGS(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .reg_sel(sel_b), .reg_data(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  // UART monitor: detect the start bit, then sample mid-bit (4 cycles per bit).
  logic [7:0] rx_mem [2][256];
  int         rx_n [2];
  int         rx_cnt [2];
  bit         rx_act [2];
  logic [7:0] rx_sh [2];
  int         frame_err [2];
  logic       mon_line;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_line = (k == 0) ? tx_a : tx_b;
      if (!rstn) begin
        rx_act[k] = 1'b0;
        rx_cnt[k] = 0;
      end else if (!rx_act[k]) begin
        if (mon_line === 1'b0) begin
          rx_act[k] = 1'b1;
          rx_cnt[k] = 0;
        end
      end else begin
        rx_cnt[k]++;
        if (rx_cnt[k] == 2 && mon_line !== 1'b0) frame_err[k]++;
        if (rx_cnt[k] >= 6 && rx_cnt[k] <= 34 && rx_cnt[k] % 4 == 2)
          rx_sh[k][rx_cnt[k] / 4 - 1] = mon_line;
        if (rx_cnt[k] == 38) begin
          if (mon_line !== 1'b1) frame_err[k]++;
          if (rx_n[k] < 256) rx_mem[k][rx_n[k]] = rx_sh[k];
          rx_n[k]++;
          rx_act[k] = 1'b0;
        end
      end
    end
  end

  // Observations captured by run_dump for the scenario tasks to judge.
  logic obs_busy_e0, obs_tx_e1, obs_tx_e2, obs_busy_next, obs_done_next;
  logic [4:0] obs_sel_pre, obs_sel_post, obs_sel_done;

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v;
    else start_b = v;
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  function automatic logic [4:0] get_sel(input int w);
    return (w == 0) ? sel_a : sel_b;
  endfunction

  // Pulse start, then count edges after E0 until done; done_at = -1 if the bound expires.
  task automatic run_dump(input int w, input int limit, input int pulse_at,
                          input bit pulse_done, input int mod_at, output int done_at);
    int cnt;
    rx_n[w] = 0;
    frame_err[w] = 0;
    @(posedge clk); #1; set_start(w, 1'b1);
    @(posedge clk); #1; set_start(w, 1'b0);
    obs_busy_e0 = get_busy(w);
    done_at = -1;
    cnt = 0;
    while (cnt < limit && done_at < 0) begin
      @(posedge clk); #1;
      cnt++;
      set_start(w, cnt == pulse_at);
      if (cnt == mod_at) rf_b[1] = 32'h5555_5555;
      if (cnt == 1) obs_tx_e1 = get_tx(w);
      if (cnt == 2) obs_tx_e2 = get_tx(w);
      if (cnt == PER_REG - 1) obs_sel_pre = get_sel(w);
      if (cnt == PER_REG) obs_sel_post = get_sel(w);
      if (get_done(w) === 1'b1) begin
        done_at = cnt;
        obs_sel_done = get_sel(w);
        if (pulse_done) set_start(w, 1'b1);
      end
    end
    @(posedge clk); #1;
    set_start(w, 1'b0);
    obs_busy_next = get_busy(w);
    obs_done_next = get_done(w);
  endtask

  task automatic test_reset;
    int toggles;
    logic last_a, last_b;
    rstn = 1'b0;
    #20 rstn = 1'b1;
    #1;
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL reset_tx_a got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done_a got %b want 0", done_a); end
    n_vec++; if (sel_a !== 5'd0) begin n_err++; $display("FAIL reset_sel_a got %0d want 0", sel_a); end
    n_vec++;
    if ({tx_b, busy_b, done_b, sel_b} !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_b got %b want 10000000", {tx_b, busy_b, done_b, sel_b});
    end
    toggles = 0;
    last_a = tx_a;
    last_b = tx_b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== last_a || tx_b !== last_b) toggles++;
      last_a = tx_a;
      last_b = tx_b;
    end
    n_vec++; if (toggles !== 0) begin n_err++; $display("FAIL idle_toggles got %0d want 0", toggles); end
  endtask

  task automatic test_byte_order;
    int d;
`ifdef RF_DUMP_IDX_EN
    logic [7:0] exp_b [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`else
    logic [7:0] exp_b [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
`endif
    rf_b[0] = 32'h0;
    rf_b[1] = 32'h1234_5678;
    run_dump(1, 2000, -1, 1'b0, -1, d);
    n_vec++; if (obs_busy_e0 !== 1'b1) begin n_err++; $display("FAIL e0_busy got %b want 1", obs_busy_e0); end
    n_vec++; if (obs_tx_e1 !== 1'b1) begin n_err++; $display("FAIL e1_tx got %b want 1", obs_tx_e1); end
    n_vec++; if (obs_tx_e2 !== 1'b0) begin n_err++; $display("FAIL e2_start_bit got %b want 0", obs_tx_e2); end
    n_vec++; if (obs_sel_pre !== 5'd0) begin n_err++; $display("FAIL sel_reg0 got %0d want 0", obs_sel_pre); end
    n_vec++; if (obs_sel_post !== 5'd1) begin n_err++; $display("FAIL sel_reg1 got %0d want 1", obs_sel_post); end
    n_vec++; if (d !== 2 * PER_REG) begin n_err++; $display("FAIL order_done_at got %0d want %0d", d, 2 * PER_REG); end
    n_vec++; if (obs_sel_done !== 5'd0) begin n_err++; $display("FAIL done_sel got %0d want 0", obs_sel_done); end
    n_vec++; if (obs_done_next !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", obs_done_next); end
    n_vec++; if (obs_busy_next !== 1'b0) begin n_err++; $display("FAIL busy_after got %b want 0", obs_busy_next); end
    n_vec++; if (rx_n[1] !== 2 * NB) begin n_err++; $display("FAIL order_count got %0d want %0d", rx_n[1], 2 * NB); end
    n_vec++; if (frame_err[1] !== 0) begin n_err++; $display("FAIL order_framing got %0d want 0", frame_err[1]); end
    for (int i = 0; i < 2 * NB; i++) begin
      n_vec++;
      if (rx_mem[1][i] !== exp_b[i]) begin
        n_err++; $display("FAIL order_byte%0d got %02h want %02h", i, rx_mem[1][i], exp_b[i]);
      end
    end
  endtask

  task automatic test_full_dump;
    int d;
    logic [7:0] e;
    run_dump(0, 20000, -1, 1'b0, -1, d);
    n_vec++; if (d !== 32 * PER_REG) begin n_err++; $display("FAIL full_done_at got %0d want %0d", d, 32 * PER_REG); end
    n_vec++; if (rx_n[0] !== 32 * NB) begin n_err++; $display("FAIL full_count got %0d want %0d", rx_n[0], 32 * NB); end
    n_vec++; if (frame_err[0] !== 0) begin n_err++; $display("FAIL full_framing got %0d want 0", frame_err[0]); end
    for (int i = 0; i < 32 * NB && i < 256; i++) begin
      e = 8'(i / NB);  // rf[n] = n*0x01010101, so every byte (and the index) equals n
      n_vec++;
      if (rx_mem[0][i] !== e) begin
        n_err++; $display("FAIL full_byte%0d got %02h want %02h", i, rx_mem[0][i], e);
      end
    end
  endtask

  task automatic test_ignored_start;
    int d;
    run_dump(0, 20000, 100, 1'b1, -1, d);
    n_vec++; if (d !== 32 * PER_REG) begin n_err++; $display("FAIL ign_done_at got %0d want %0d", d, 32 * PER_REG); end
    n_vec++; if (obs_busy_next !== 1'b0) begin n_err++; $display("FAIL ign_busy_after got %b want 0", obs_busy_next); end
    repeat (60) @(posedge clk);
    #1;
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL ign_no_restart got %b want 0", busy_a); end
    n_vec++; if (rx_n[0] !== 32 * NB) begin n_err++; $display("FAIL ign_count got %0d want %0d", rx_n[0], 32 * NB); end
  endtask

  task automatic test_reset_mid_dump;
    int d;
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (100) @(posedge clk);
    #1;  // E0+100: inside DATA of the third byte of register 0 (all zero bits)
    n_vec++; if (tx_a !== 1'b0) begin n_err++; $display("FAIL mid_tx_before got %b want 0", tx_a); end
    rstn = 1'b0;
    #1;
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL mid_tx_reset got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_busy_reset got %b want 0", busy_a); end
    n_vec++; if (sel_a !== 5'd0) begin n_err++; $display("FAIL mid_sel_reset got %0d want 0", sel_a); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run_dump(0, 20000, -1, 1'b0, -1, d);
    n_vec++; if (d !== 32 * PER_REG) begin n_err++; $display("FAIL mid_done_at got %0d want %0d", d, 32 * PER_REG); end
    n_vec++; if (rx_n[0] !== 32 * NB) begin n_err++; $display("FAIL mid_count got %0d want %0d", rx_n[0], 32 * NB); end
    n_vec++; if (rx_mem[0][0] !== 8'h00) begin n_err++; $display("FAIL mid_first got %02h want 00", rx_mem[0][0]); end
    n_vec++; if (rx_mem[0][NB] !== 8'h01) begin n_err++; $display("FAIL mid_reg1 got %02h want 01", rx_mem[0][NB]); end
    n_vec++;
    if (rx_mem[0][32 * NB - 1] !== 8'h1f) begin
      n_err++; $display("FAIL mid_last got %02h want 1f", rx_mem[0][32 * NB - 1]);
    end
  endtask

  task automatic test_sampling_point;
    int d;
    rf_b[0] = 32'h0;
    rf_b[1] = 32'hAAAA_AAAA;
    // Register 1 is latched at edge E0+PER_REG+2; modify it right after that edge.
    run_dump(1, 2000, -1, 1'b0, PER_REG + 2, d);
    n_vec++; if (d !== 2 * PER_REG) begin n_err++; $display("FAIL samp_done_at got %0d want %0d", d, 2 * PER_REG); end
    n_vec++; if (rx_n[1] !== 2 * NB) begin n_err++; $display("FAIL samp_count got %0d want %0d", rx_n[1], 2 * NB); end
    for (int i = 2 * NB - 4; i < 2 * NB; i++) begin
      n_vec++;
      if (rx_mem[1][i] !== 8'hAA) begin
        n_err++; $display("FAIL samp_byte%0d got %02h want aa", i, rx_mem[1][i]);
      end
    end
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_a[i] = 32'(i) * 32'h0101_0101;
      rf_b[i] = 32'h0;
    end
    test_reset();
    test_byte_order();
    test_full_dump();
    test_ignored_start();
    test_reset_mid_dump();
    test_sampling_point();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
